cram_rd_slave: RTL and testbench
================================

CRAM_RD_SLAVE -- requirements
Module: cram_rd_slave

Interface
REQ-001 SHALL have parameter CRAM_ADDR_W, default fcpu_pkg CRAM_ADDR_W (15), byte-address width of the code RAM.
REQ-002 SHALL have parameter DATA_W, default fcpu_pkg DATA_W (32), read data width.
REQ-003 SHALL provide the following ports, clock and reset first:
  clk  in  1  sole clock; all state updates on the rising edge.
  nrst  in  1  synchronous, active-low reset.
  s_cram_arid / arlen / arsize / arburst  in  4/8/3/2  AXI4 read-address fields.
  s_cram_araddr  in  32  byte address.
  s_cram_arlock / arcache / arprot / arqos  in  1/4/3/4  accepted, ignored.
  s_cram_arvalid  in  1; s_cram_arready  out  1.
  s_cram_rid  out  4; s_cram_rdata  out  DATA_W; s_cram_rresp  out  2; s_cram_rlast  out  1.
  s_cram_rvalid  out  1; s_cram_rready  in  1.
  cram_we  in  1  loader write strobe.
  cram_waddr  in  CRAM_ADDR_W-2  loader word address.
  cram_wdata  in  DATA_W  loader write data.

Function
REQ-004 SHALL hold 2^(CRAM_ADDR_W-2) words; word index = araddr[CRAM_ADDR_W-1:2]; araddr[1:0] ignored.
REQ-005 SHALL complete an AR handshake when s_cram_arvalid and s_cram_arready are both high.
REQ-006 SHALL drive s_cram_arready high only in state IDLE with nrst high and (occ + pend) < 3, where occ = output-FIFO entries at cycle start and pend = 1 if a memory read was issued in the previous cycle.
REQ-007 SHALL issue the beat-0 memory read in the AR handshake cycle T and present beat 0 on the R channel no earlier than T+2 (T+2 when the FIFO is empty).
REQ-008 SHALL buffer read beats in a 3-entry output FIFO; s_cram_rvalid = FIFO not empty; a beat is popped when s_cram_rvalid and s_cram_rready are both high.
REQ-009 SHALL hold s_cram_rid, s_cram_rdata, s_cram_rresp and s_cram_rlast stable while s_cram_rvalid is high and s_cram_rready is low.
REQ-010 SHALL sustain one beat per cycle with back-to-back single-beat requests while s_cram_rready stays high.
REQ-011 SHALL have states IDLE and BURST. IDLE goes to BURST on a handshake with effective arlen > 0; BURST goes to IDLE in the cycle the final beat's read is issued; s_cram_arready is low in BURST.
REQ-012 SHALL issue a BURST beat read only when (occ + pend) < 3.
REQ-013 SHALL advance the address per beat as follows: INCR (01) +1 word, wrapping modulo memory depth; FIXED (00) unchanged; WRAP (10) and reserved (11) return SLVERR (2'b10) with rdata 0 on every beat.
REQ-014 SHALL return SLVERR with rdata 0 on every beat when arsize != 3'b010.
REQ-015 SHALL return DECERR (2'b11) with rdata 0 on every beat when araddr[31:CRAM_ADDR_W] != 0; DECERR takes priority over SLVERR.
REQ-016 SHALL otherwise return OKAY (2'b00); rid echoes arid on every beat; rlast is high on the final beat only.
REQ-017 SHALL return the old word when a loader write and a memory read hit the same address in the same cycle (read-first).

Reset
REQ-018 SHALL, while nrst is low at a clock edge, empty the FIFO, clear pend, enter IDLE and discard in-flight beats; s_cram_rvalid and s_cram_arready are 0 in the following cycle.
REQ-019 SHALL reset outputs as rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, arready=0 (arready stays 0 while nrst is low); memory contents are not reset.

Configuration
REQ-020 SHALL, with CRAM_BURST_EN defined, honor s_cram_arlen (1..256 beats).
REQ-021 SHALL, without CRAM_BURST_EN, treat arlen as 0: every request returns exactly one beat with rlast=1, and the BURST state and its beat counter are not compiled in.

Structure
REQ-022 SHALL define in fcpu_pkg the AXI response constants (RESP_OKAY, RESP_SLVERR, RESP_DECERR), the state enum type, and a packed R-beat struct {id, data, resp, last}.
REQ-023 SHALL instantiate one sub-module, cram_bram: 1 write port, 1 read port, 1-cycle synchronous read, read-first.

Verification
REQ-024 Load word 5 = 0xDEADBEEF; AR araddr=0x14, arlen=0 at cycle T -> rvalid at T+2, rdata=0xDEADBEEF, rresp=0, rlast=1.
REQ-025 arvalid held high, araddr 0,4,8,... for 16 cycles with rready=1 -> 16 consecutive beats, one per cycle, in address order.
REQ-026 CRAM_BURST_EN defined; araddr=0x7FFC, arlen=2, INCR, rid=3 -> words 0x1FFF, 0, 1 returned; rid=3 on all beats; rlast on the third beat only.
REQ-027 rready=0 for 10 cycles during a burst -> at most 3 beats buffered, rdata stable, no beat lost or duplicated after release.
REQ-028 araddr=0x8000 -> DECERR, rdata 0; arsize=1 -> SLVERR; nrst low mid-burst -> rvalid=0 the next cycle and no stale beat after reset.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared fcpu types for the code-RAM read slave:
// AXI response codes, FSM state type and the R-beat bundle.
package fcpu_pkg;

  localparam int CRAM_ADDR_W = 15;
  localparam int DATA_W      = 32;
  localparam int FIFO_DEPTH  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  typedef struct packed {
    logic [3:0]        id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  // Pointer step for the 3-entry ring.
  function automatic logic [1:0] ptr_nxt(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cram_rd_slave_if.sv
// AXI4 read-channel bundle for the code-RAM slave.
// slave modport faces the RAM side, master faces the CPU side.
interface cram_rd_slave_if #(
  parameter int DATA_W = fcpu_pkg::DATA_W
);

  logic [3:0]        s_cram_arid;
  logic [31:0]       s_cram_araddr;
  logic [7:0]        s_cram_arlen;
  logic [2:0]        s_cram_arsize;
  logic [1:0]        s_cram_arburst;
  logic              s_cram_arlock;
  logic [3:0]        s_cram_arcache;
  logic [2:0]        s_cram_arprot;
  logic [3:0]        s_cram_arqos;
  logic              s_cram_arvalid;
  logic              s_cram_arready;
  logic [3:0]        s_cram_rid;
  logic [DATA_W-1:0] s_cram_rdata;
  logic [1:0]        s_cram_rresp;
  logic              s_cram_rlast;
  logic              s_cram_rvalid;
  logic              s_cram_rready;

  modport slave (
    input  s_cram_arid,
    input  s_cram_araddr,
    input  s_cram_arlen,
    input  s_cram_arsize,
    input  s_cram_arburst,
    input  s_cram_arlock,
    input  s_cram_arcache,
    input  s_cram_arprot,
    input  s_cram_arqos,
    input  s_cram_arvalid,
    output s_cram_arready,
    output s_cram_rid,
    output s_cram_rdata,
    output s_cram_rresp,
    output s_cram_rlast,
    output s_cram_rvalid,
    input  s_cram_rready
  );

  modport master (
    output s_cram_arid,
    output s_cram_araddr,
    output s_cram_arlen,
    output s_cram_arsize,
    output s_cram_arburst,
    output s_cram_arlock,
    output s_cram_arcache,
    output s_cram_arprot,
    output s_cram_arqos,
    output s_cram_arvalid,
    input  s_cram_arready,
    input  s_cram_rid,
    input  s_cram_rdata,
    input  s_cram_rresp,
    input  s_cram_rlast,
    input  s_cram_rvalid,
    output s_cram_rready
  );

endinterface

// File: rtl/cram_bram.sv
// Simple dual-port code RAM: one write port, one read port,
// 1-cycle synchronous read returning the pre-write word.
module cram_bram #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cram_rd_slave.sv
// AXI4 read-only slave for the code RAM with a 3-beat R FIFO.
// Define CRAM_BURST_EN to honor arlen; otherwise one beat per AR.
module cram_rd_slave #(
  parameter int CRAM_ADDR_W = fcpu_pkg::CRAM_ADDR_W,
  parameter int DATA_W      = fcpu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  cram_rd_slave_if.slave         s_cram,
  input  logic                   cram_we,
  input  logic [CRAM_ADDR_W-3:0] cram_waddr,
  input  logic [DATA_W-1:0]      cram_wdata
);

  import fcpu_pkg::*;

  localparam int WA = CRAM_ADDR_W - 2;

  typedef struct packed {
    logic [3:0]        id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  beat_t       r_fifo [FIFO_DEPTH];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_occ;
  logic        r_pend;
  logic [3:0]  r_p_id;
  logic [1:0]  r_p_resp;
  logic        r_p_last;

  logic          w_idle;
  logic          w_room;
  logic          w_arready;
  logic          w_ar_hs;
  logic [1:0]    w_ar_resp;
  logic [WA-1:0] w_ar_addr;
  logic          w_iss;
  logic [WA-1:0] w_iss_addr;
  logic [3:0]    w_iss_id;
  logic [1:0]    w_iss_resp;
  logic          w_iss_last;
  logic          w_rvalid;
  logic          w_pop;
  logic [DATA_W-1:0] w_mem_rdata;
  beat_t         w_push_beat;
  beat_t         w_head;
  logic          w_unused;

  // Count a read already in the RAM pipe so the FIFO never overflows.
  assign w_room = ({1'b0, r_occ} + {2'b00, r_pend}) < 3'd3;
  assign w_arready = nrst & w_idle & w_room;
  assign w_ar_hs = s_cram.s_cram_arvalid & w_arready;
  assign w_ar_addr = s_cram.s_cram_araddr[CRAM_ADDR_W-1:2];

  always_comb begin
    w_ar_resp = RESP_OKAY;
    if (s_cram.s_cram_araddr[31:CRAM_ADDR_W] != '0)
      w_ar_resp = RESP_DECERR;
    else if (s_cram.s_cram_arsize != SIZE_WORD ||
             s_cram.s_cram_arburst[1])
      w_ar_resp = RESP_SLVERR;
  end

`ifdef CRAM_BURST_EN
  state_e        r_state;
  logic [WA-1:0] r_addr;
  logic [7:0]    r_left;
  logic [3:0]    r_id;
  logic [1:0]    r_resp;
  logic          r_fixed;

  assign w_idle = (r_state == ST_IDLE);

  always_comb begin
    w_iss      = w_ar_hs;
    w_iss_addr = w_ar_addr;
    w_iss_id   = s_cram.s_cram_arid;
    w_iss_resp = w_ar_resp;
    w_iss_last = (s_cram.s_cram_arlen == 8'd0);
    if (r_state == ST_BURST) begin
      w_iss      = w_room;
      w_iss_addr = r_addr;
      w_iss_id   = r_id;
      w_iss_resp = r_resp;
      w_iss_last = (r_left == 8'd1);
    end
  end

  // r_left holds the beats still to issue after the current one.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_left  <= '0;
      r_id    <= '0;
      r_resp  <= RESP_OKAY;
      r_fixed <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_ar_hs && s_cram.s_cram_arlen != 8'd0) begin
            r_state <= ST_BURST;
            r_left  <= s_cram.s_cram_arlen;
            r_id    <= s_cram.s_cram_arid;
            r_resp  <= w_ar_resp;
            r_fixed <= (s_cram.s_cram_arburst == BURST_FIXED);
            r_addr  <= (s_cram.s_cram_arburst == BURST_FIXED)
                     ? w_ar_addr : w_ar_addr + WA'(1);
          end
        end
        ST_BURST: begin
          if (w_room) begin
            r_left <= r_left - 8'd1;
            if (!r_fixed) r_addr <= r_addr + WA'(1);
            if (r_left == 8'd1) r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign w_unused = ^{s_cram.s_cram_arlock,
                      s_cram.s_cram_arcache,
                      s_cram.s_cram_arprot,
                      s_cram.s_cram_arqos,
                      s_cram.s_cram_araddr[1:0]};
`else
  assign w_idle = 1'b1;

  always_comb begin
    w_iss      = w_ar_hs;
    w_iss_addr = w_ar_addr;
    w_iss_id   = s_cram.s_cram_arid;
    w_iss_resp = w_ar_resp;
    w_iss_last = 1'b1;
  end

  assign w_unused = ^{s_cram.s_cram_arlock,
                      s_cram.s_cram_arcache,
                      s_cram.s_cram_arprot,
                      s_cram.s_cram_arqos,
                      s_cram.s_cram_araddr[1:0],
                      s_cram.s_cram_arlen,
                      s_cram.s_cram_arburst[0]};
`endif

  cram_bram #(
    .AW (WA),
    .DW (DATA_W)
  ) u_bram (
    .clk     (clk),
    .i_we    (cram_we),
    .i_waddr (cram_waddr),
    .i_wdata (cram_wdata),
    .i_re    (w_iss),
    .i_raddr (w_iss_addr),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_push_beat.id   = r_p_id;
    w_push_beat.resp = r_p_resp;
    w_push_beat.last = r_p_last;
    w_push_beat.data = (r_p_resp == RESP_OKAY)
                     ? w_mem_rdata : '0;
  end

  assign w_rvalid = (r_occ != 2'd0);
  assign w_pop = w_rvalid & s_cram.s_cram_rready;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_pend   <= 1'b0;
      r_p_id   <= '0;
      r_p_resp <= RESP_OKAY;
      r_p_last <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_pend   <= w_iss;
      r_p_id   <= w_iss_id;
      r_p_resp <= w_iss_resp;
      r_p_last <= w_iss_last;
      if (r_pend) r_wr_ptr <= ptr_nxt(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_nxt(r_rd_ptr);
      r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (r_pend) r_fifo[r_wr_ptr] <= w_push_beat;
  end

  assign w_head = w_rvalid ? r_fifo[r_rd_ptr] : '0;

  assign s_cram.s_cram_arready = w_arready;
  assign s_cram.s_cram_rvalid  = w_rvalid;
  assign s_cram.s_cram_rid     = w_head.id;
  assign s_cram.s_cram_rdata   = w_head.data;
  assign s_cram.s_cram_rresp   = w_head.resp;
  assign s_cram.s_cram_rlast   = w_head.last;

endmodule

// File: tb/tb_cram_rd_slave.sv
// Scoreboard bench for cram_rd_slave against a word-array model.
// Burst scenarios are added when CRAM_BURST_EN is defined.
module tb_cram_rd_slave;

  import fcpu_pkg::*;

  localparam int WA    = CRAM_ADDR_W - 2;
  localparam int DEPTH = 1 << WA;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              cram_we = 1'b0;
  logic [WA-1:0]     cram_waddr = '0;
  logic [DATA_W-1:0] cram_wdata = '0;

  cram_rd_slave_if #(.DATA_W(DATA_W)) bus ();

  cram_rd_slave dut (
    .clk        (clk),
    .nrst       (nrst),
    .s_cram     (bus),
    .cram_we    (cram_we),
    .cram_waddr (cram_waddr),
    .cram_wdata (cram_wdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int rr_mode = 0;

  logic [31:0] mem [DEPTH];
  rbeat_t exp_q[$];
  int stamps[$];
  logic stalled = 1'b0;
  rbeat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: expand one request into its expected beats.
  task automatic model_push(input logic [3:0] id,
                            input logic [31:0] addr,
                            input logic [7:0] len,
                            input logic [2:0] size,
                            input logic [1:0] burst);
    int beats;
    int idx;
    logic [1:0] resp;
    rbeat_t e;
`ifdef CRAM_BURST_EN
    beats = int'(len) + 1;
`else
    beats = 1;
    if (len == 8'hxx) beats = 1;
`endif
    if ((addr >> CRAM_ADDR_W) != 0) resp = 2'b11;
    else if (size != 3'd2 || burst >= 2'd2) resp = 2'b10;
    else resp = 2'b00;
    idx = int'(addr % (32'd1 << CRAM_ADDR_W)) / 4;
    for (int b = 0; b < beats; b++) begin
      e.id   = id;
      e.data = (resp == 2'b00) ? mem[idx] : 32'h0;
      e.resp = resp;
      e.last = (b == beats - 1);
      exp_q.push_back(e);
      if (burst == 2'b01) idx = (idx + 1) % DEPTH;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_ar(input logic [3:0] id,
                         input logic [31:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input logic [1:0] burst);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    bus.s_cram_arid    = id;
    bus.s_cram_araddr  = addr;
    bus.s_cram_arlen   = len;
    bus.s_cram_arsize  = size;
    bus.s_cram_arburst = burst;
    bus.s_cram_arlock  = 1'($urandom);
    bus.s_cram_arcache = 4'($urandom);
    bus.s_cram_arprot  = 3'($urandom);
    bus.s_cram_arqos   = 4'($urandom);
    bus.s_cram_arvalid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = bus.s_cram_arready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.s_cram_arvalid = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ar_timeout: got no arready expected handshake");
    end else begin
      hs_cnt++;
      model_push(id, addr, len, size, burst);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    cram_waddr = WA'(idx);
    cram_wdata = val;
    cram_we = 1'b1;
    mem[idx] = val;
    @(posedge clk);
    #1;
    cram_we = 1'b0;
  endtask

  // Monitor: compare every accepted beat, and hold steady under stall.
  always @(negedge clk) begin
    rbeat_t cur;
    rbeat_t e;
    cur.id   = bus.s_cram_rid;
    cur.data = bus.s_cram_rdata;
    cur.resp = bus.s_cram_rresp;
    cur.last = bus.s_cram_rlast;
    if (nrst && bus.s_cram_rvalid) begin
      if (stalled) chk("r_stable", 64'(cur), 64'(held));
      if (bus.s_cram_rready) begin
        stalled <= 1'b0;
        stamps.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL r_extra: got beat %h expected none",
                   cur);
        end else begin
          e = exp_q.pop_front();
          chk("r_beat", 64'(cur), 64'(e));
        end
      end else begin
        stalled <= 1'b1;
        held <= cur;
      end
    end else begin
      stalled <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: bus.s_cram_rready = 1'b1;
        1: bus.s_cram_rready = ($urandom % 3) != 0;
        default: bus.s_cram_rready = 1'b0;
      endcase
    end
  end

  initial begin
    int hs0;
    logic [31:0] a;
    logic [2:0] sz;
    logic [1:0] bt;
    logic [7:0] ln;
    bus.s_cram_rready  = 1'b1;
    bus.s_cram_arvalid = 1'b0;
    bus.s_cram_arid    = '0;
    bus.s_cram_araddr  = '0;
    bus.s_cram_arlen   = '0;
    bus.s_cram_arsize  = '0;
    bus.s_cram_arburst = '0;
    bus.s_cram_arlock  = '0;
    bus.s_cram_arcache = '0;
    bus.s_cram_arprot  = '0;
    bus.s_cram_arqos   = '0;

    repeat (3) @(posedge clk);
    #1;
    // Fill memory during reset; contents are not cleared by reset.
    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    @(negedge clk);
    chk("rst_rvalid", 64'(bus.s_cram_rvalid), 64'd0);
    chk("rst_arready", 64'(bus.s_cram_arready), 64'd0);
    chk("rst_rid", 64'(bus.s_cram_rid), 64'd0);
    chk("rst_rdata", 64'(bus.s_cram_rdata), 64'd0);
    chk("rst_rresp", 64'(bus.s_cram_rresp), 64'd0);
    chk("rst_rlast", 64'(bus.s_cram_rlast), 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    load(5, 32'hDEADBEEF);

    // Single read latency with empty FIFO.
    send_ar(4'd1, 32'h14, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    chk("lat_t1_rvalid", 64'(bus.s_cram_rvalid), 64'd0);
    @(negedge clk);
    chk("lat_t2_rvalid", 64'(bus.s_cram_rvalid), 64'd1);
    chk("lat_t2_rdata", 64'(bus.s_cram_rdata), 64'hDEADBEEF);
    chk("lat_t2_rlast", 64'(bus.s_cram_rlast), 64'd1);
    chk("lat_t2_rresp", 64'(bus.s_cram_rresp), 64'd0);
    @(posedge clk);
    #1;
    wait_drain(50);

    // Back-to-back single beats at full rate.
    stamps.delete();
    for (int i = 0; i < 16; i++)
      send_ar(4'(i), 32'(i * 4), 8'd0, 3'd2, 2'b01);
    wait_drain(50);
    chk("tput_n", 64'(stamps.size()), 64'd16);
    if (stamps.size() == 16)
      chk("tput_span", 64'(stamps[15] - stamps[0]), 64'd15);

    // Error responses.
    send_ar(4'd2, 32'h8000, 8'd0, 3'd2, 2'b01);
    send_ar(4'd3, 32'h10, 8'd0, 3'd1, 2'b01);
    send_ar(4'd4, 32'h8010, 8'd0, 3'd1, 2'b10);
    send_ar(4'd5, 32'h20, 8'd0, 3'd2, 2'b10);
    send_ar(4'd6, 32'h24, 8'd0, 3'd2, 2'b11);
    send_ar(4'd7, 32'h28, 8'd0, 3'd2, 2'b00);
    wait_drain(50);

    // Back-pressure: only three reads may be in flight.
    rr_mode = 2;
    @(posedge clk);
    #1;
    hs0 = hs_cnt;
    fork
      for (int i = 0; i < 5; i++)
        send_ar(4'(8 + i), 32'(64 + i * 4), 8'd0, 3'd2, 2'b01);
    join_none
    repeat (12) @(negedge clk);
    chk("stall_hs", 64'(hs_cnt - hs0), 64'd3);
    chk("stall_arready", 64'(bus.s_cram_arready), 64'd0);
    chk("stall_rvalid", 64'(bus.s_cram_rvalid), 64'd1);
    @(posedge clk);
    #1;
    rr_mode = 0;
    wait fork;
    wait_drain(100);

`ifdef CRAM_BURST_EN
    load(DEPTH - 1, 32'h1111_AAAA);
    load(0, 32'h2222_BBBB);
    load(1, 32'h3333_CCCC);
    send_ar(4'd3, 32'h7FFC, 8'd2, 3'd2, 2'b01);
    wait_drain(50);
    send_ar(4'd9, 32'h40, 8'd3, 3'd2, 2'b00);
    send_ar(4'd10, 32'h8000, 8'd2, 3'd2, 2'b01);
    send_ar(4'd11, 32'h40, 8'd1, 3'd2, 2'b10);
    wait_drain(50);
    rr_mode = 2;
    @(posedge clk);
    #1;
    fork
      send_ar(4'd12, 32'h100, 8'd7, 3'd2, 2'b01);
    join_none
    repeat (12) @(negedge clk);
    chk("bstall_rvalid", 64'(bus.s_cram_rvalid), 64'd1);
    chk("bstall_arready", 64'(bus.s_cram_arready), 64'd0);
    @(posedge clk);
    #1;
    rr_mode = 0;
    wait fork;
    wait_drain(100);
`endif

    // Reset with beats in flight.
    rr_mode = 2;
    @(posedge clk);
    #1;
`ifdef CRAM_BURST_EN
    send_ar(4'd13, 32'h200, 8'd10, 3'd2, 2'b01);
`else
    send_ar(4'd13, 32'h200, 8'd0, 3'd2, 2'b01);
    send_ar(4'd14, 32'h204, 8'd0, 3'd2, 2'b01);
`endif
    @(posedge clk);
    #1;
    nrst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_arready", 64'(bus.s_cram_arready), 64'd0);
    @(negedge clk);
    chk("mrst_rvalid", 64'(bus.s_cram_rvalid), 64'd0);
    chk("mrst_rdata", 64'(bus.s_cram_rdata), 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    rr_mode = 0;
    stamps.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_no_stale", 64'(stamps.size()), 64'd0);

    // Randomized traffic with random back-pressure.
    rr_mode = 1;
    for (int i = 0; i < 200; i++) begin
      a = ($urandom % 8 == 0) ? $urandom
                              : 32'($urandom_range(0, 32'h7FFF));
      sz = ($urandom % 6 == 0) ? 3'($urandom) : 3'd2;
      bt = ($urandom % 5 == 0) ? 2'($urandom)
         : (($urandom % 4 == 0) ? 2'b00 : 2'b01);
      ln = ($urandom % 10 == 0) ? 8'($urandom_range(0, 40))
                                : 8'($urandom_range(0, 4));
      send_ar(4'($urandom), a, ln, sz, bt);
    end
    wait_drain(5000);
    rr_mode = 0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
